// File: rtl/keyed_spectrum_reorder_if.sv
// Sample-stream bundle for keyed_spectrum_reorder: natural-order FFT bins in,
// key-scrambled bins out. The reorder block uses the slave modport.
interface keyed_spectrum_reorder_if #(
  parameter int DW = 16
);
  logic          di_en;
  logic [23:0]   shift_key;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          do_en;
  logic [6:0]    do_count;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;

  modport master (
    output di_en, shift_key, in_real, in_imag,
    input  do_en, do_count, out_real, out_imag
  );

  modport slave (
    input  di_en, shift_key, in_real, in_imag,
    output do_en, do_count, out_real, out_imag
  );
endinterface

// File: rtl/keyed_spectrum_reorder.sv
// Ping-pong 128-bin spectrum reorder: eight 8-bin bands of the lower half are
// shuffled by a per-frame key, and the upper half is shuffled as their mirror.
module keyed_spectrum_reorder #(
  parameter int DW = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  keyed_spectrum_reorder_if.slave bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [2:0]      key_field [8];
  logic [2:0]      perm_comb [8];
  logic [2:0]      perm_bank_reg [2][8];

  logic [6:0]      in_cnt_reg;
  logic [6:0]      out_cnt_reg;
  logic            wr_bank_reg;
  logic            rd_bank_reg;

  logic            frame_start;
  logic            frame_done;
  logic            rd_en;

  logic [5:0]      fold;
  logic [5:0]      src_low;
  logic [6:0]      src_idx;

  logic [2*DW-1:0] mem [256];
  logic [2*DW-1:0] rd_word_reg;
  logic [6:0]      do_count_reg;
  logic            do_en_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_key_field
    assign key_field[gi] = bus.shift_key[3*gi +: 3];
  end

  // Backward Fisher-Yates over the eight bands; the i = 0 step is always a no-op swap.
  always_comb begin
    logic [2:0] j;
    logic [2:0] tmp;
    j   = 3'd0;
    tmp = 3'd0;
    for (int i = 0; i < 8; i++) begin
      perm_comb[i] = 3'(i);
    end
    for (int i = 7; i >= 0; i--) begin
      j            = 3'(i - (int'(key_field[i]) % (i + 1)));
      tmp          = perm_comb[i];
      perm_comb[i] = perm_comb[j];
      perm_comb[j] = tmp;
    end
  end

  assign frame_start = bus.di_en && (in_cnt_reg == 7'd0);
  assign frame_done  = bus.di_en && (in_cnt_reg == 7'd127);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A new frame completing exactly on the last output bin keeps the stream gap-free.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (frame_done) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if ((out_cnt_reg == 7'd127) && !frame_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    case (state_reg)
      STREAM:  rd_en = 1'b1;
      default: rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      in_cnt_reg  <= 7'd0;
      out_cnt_reg <= 7'd0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          perm_bank_reg[b][i] <= 3'(i);
        end
      end
    end else begin
      if (bus.di_en) begin
        in_cnt_reg <= in_cnt_reg + 7'd1;
      end
      if (frame_start) begin
        for (int i = 0; i < 8; i++) begin
          perm_bank_reg[wr_bank_reg][i] <= perm_comb[i];
        end
      end
      if (frame_done) begin
        wr_bank_reg <= ~wr_bank_reg;
        rd_bank_reg <= wr_bank_reg;
        out_cnt_reg <= 7'd0;
      end else if (rd_en) begin
        out_cnt_reg <= out_cnt_reg + 7'd1;
      end
    end
  end

  // Upper-half bins index from the top (127-k), which is the bitwise inverse of k[5:0].
  always_comb begin
    fold    = out_cnt_reg[6] ? ~out_cnt_reg[5:0] : out_cnt_reg[5:0];
    src_low = {perm_bank_reg[rd_bank_reg][fold[5:3]], fold[2:0]};
    src_idx = out_cnt_reg[6] ? {1'b1, ~src_low} : {1'b0, src_low};
  end

  always_ff @(posedge clock) begin
    if (reset && bus.di_en) begin
      mem[{wr_bank_reg, in_cnt_reg}] <= {bus.in_real, bus.in_imag};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_word_reg  <= '0;
      do_count_reg <= 7'd0;
      do_en_reg    <= 1'b0;
    end else begin
      do_en_reg <= rd_en;
      if (rd_en) begin
        rd_word_reg  <= mem[{rd_bank_reg, src_idx}];
        do_count_reg <= out_cnt_reg;
      end
    end
  end

  assign bus.do_en    = do_en_reg;
  assign bus.do_count = do_count_reg;
  assign bus.out_real = rd_word_reg[2*DW-1:DW];
  assign bus.out_imag = rd_word_reg[DW-1:0];

endmodule

// File: tb/tb_keyed_spectrum_reorder.sv
// Directed bench for keyed_spectrum_reorder: ramps through identity, keyed,
// back-to-back, gapped, reset-interrupted and key-change frames.
module tb_keyed_spectrum_reorder;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  keyed_spectrum_reorder_if #(.DW(DW)) bus ();

  keyed_spectrum_reorder #(.DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Band tables worked out by hand from the key-to-permutation rule.
  int perm_id [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int perm_67 [8] = '{0, 1, 2, 3, 4, 5, 7, 6};
  int perm_ff [8] = '{5, 3, 1, 7, 2, 4, 6, 0};

  function automatic int exp_src(input int k, input int p [8]);
    int r;
    if (k < 64) return 8 * p[k / 8] + k % 8;
    r = 127 - k;
    return 127 - (8 * p[r / 8] + r % 8);
  endfunction

  task automatic drive(input logic en, input logic [23:0] key, input int val);
    bus.di_en     = en;
    bus.shift_key = key;
    bus.in_real   = 16'(val);
    bus.in_imag   = 16'(-val);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 24'h0, 0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 24'hABCDEF, 77);
    tick(); tick(); tick();
    n_checks++;
    if (bus.do_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_do_en: got %b, expected 0", bus.do_en);
    end
    n_checks++;
    if (bus.do_count !== 7'd0) begin
      n_fail++; $display("FAIL reset_do_count: got %0d, expected 0", bus.do_count);
    end
    n_checks++;
    if (bus.out_real !== 16'd0) begin
      n_fail++; $display("FAIL reset_out_real: got %h, expected 0", bus.out_real);
    end
    n_checks++;
    if (bus.out_imag !== 16'd0) begin
      n_fail++; $display("FAIL reset_out_imag: got %h, expected 0", bus.out_imag);
    end
    reset = 1'b1;
    drive(1'b0, 24'h0, 0);
    $display("test_reset: done");
  endtask

  task automatic test_identity();
    int k;
    do_reset();
    for (int c = 0; c <= 260; c++) begin
      tick();
      n_checks++;
      if (c >= 129 && c <= 256) begin
        k = c - 129;
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(k) || bus.out_imag !== 16'(-k)) begin
          n_fail++;
          $display("FAIL identity c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, k, -k);
        end
      end else if (c > 256) begin
        if (bus.do_en !== 1'b0 || bus.do_count !== 7'd127 ||
            bus.out_real !== 16'd127 || bus.out_imag !== 16'(-127)) begin
          n_fail++;
          $display("FAIL identity_hold c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=0 cnt=127 re=127 im=-127",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag));
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL identity_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c < 128) drive(1'b1, 24'h0, c); else drive(1'b0, 24'h0, 0);
    end
    $display("test_identity: done");
  endtask

  task automatic test_permuted();
    int k, ev;
    int spot_k [4] = '{48, 56, 71, 79};
    int spot_v [4] = '{56, 48, 79, 71};
    do_reset();
    for (int c = 0; c <= 259; c++) begin
      tick();
      n_checks++;
      if (c >= 129 && c <= 256) begin
        k  = c - 129;
        ev = exp_src(k, perm_67);
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(ev) || bus.out_imag !== 16'(-ev)) begin
          n_fail++;
          $display("FAIL permuted c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, ev, -ev);
        end
        for (int s = 0; s < 4; s++) begin
          if (k == spot_k[s]) begin
            n_checks++;
            if (bus.out_real !== 16'(spot_v[s])) begin
              n_fail++;
              $display("FAIL permuted_spot k=%0d: re=%0d, expected %0d", k, bus.out_real, spot_v[s]);
            end
          end
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL permuted_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c < 128) drive(1'b1, 24'h200000, c); else drive(1'b0, 24'h0, 0);
    end
    $display("test_permuted: done");
  endtask

  task automatic test_back_to_back();
    int k, f, ev;
    do_reset();
    for (int c = 0; c <= 388; c++) begin
      tick();
      n_checks++;
      if (c >= 129 && c <= 384) begin
        k  = (c - 129) % 128;
        f  = (c - 129) / 128;
        ev = (f == 0) ? 1000 + exp_src(k, perm_id) : 2000 + exp_src(k, perm_67);
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(ev) || bus.out_imag !== 16'(-ev)) begin
          n_fail++;
          $display("FAIL back_to_back c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, ev, -ev);
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL back_to_back_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c < 128)      drive(1'b1, 24'h0, 1000 + c);
      else if (c < 256) drive(1'b1, 24'h200000, 2000 + c - 128);
      else              drive(1'b0, 24'h0, 0);
    end
    $display("test_back_to_back: done");
  endtask

  task automatic test_gap();
    int k, ev;
    do_reset();
    for (int c = 0; c <= 265; c++) begin
      tick();
      n_checks++;
      if (c >= 134 && c <= 261) begin
        k  = c - 134;
        ev = 3000 + k;
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(ev) || bus.out_imag !== 16'(-ev)) begin
          n_fail++;
          $display("FAIL gap c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, ev, -ev);
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL gap_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c <= 60)       drive(1'b1, 24'h0, 3000 + c);
      else if (c <= 65)  drive(1'b0, 24'h0, 999);
      else if (c <= 132) drive(1'b1, 24'h0, 3000 + c - 5);
      else               drive(1'b0, 24'h0, 0);
    end
    $display("test_gap: done");
  endtask

  task automatic test_reset_mid_frame();
    int k, ev;
    do_reset();
    for (int c = 0; c <= 300; c++) begin
      tick();
      n_checks++;
      if (c >= 170 && c <= 297) begin
        k  = c - 170;
        ev = 4000 + k;
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(ev) || bus.out_imag !== 16'(-ev)) begin
          n_fail++;
          $display("FAIL reset_mid c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, ev, -ev);
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c < 40) begin
        drive(1'b1, 24'h200000, 500 + c);
      end else if (c == 40) begin
        drive(1'b1, 24'h200000, 500 + c);
        reset = 1'b0;
      end else if (c <= 168) begin
        reset = 1'b1;
        drive(1'b1, 24'h0, 4000 + c - 41);
      end else begin
        drive(1'b0, 24'h0, 0);
      end
    end
    $display("test_reset_mid_frame: done");
  endtask

  task automatic test_key_change();
    int k, ev;
    do_reset();
    for (int c = 0; c <= 258; c++) begin
      tick();
      n_checks++;
      if (c >= 129 && c <= 256) begin
        k  = c - 129;
        ev = 5000 + exp_src(k, perm_ff);
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'(k) ||
            bus.out_real !== 16'(ev) || bus.out_imag !== 16'(-ev)) begin
          n_fail++;
          $display("FAIL key_change c=%0d: en=%b cnt=%0d re=%0d im=%0d, expected en=1 cnt=%0d re=%0d im=%0d",
                   c, bus.do_en, bus.do_count, $signed(bus.out_real), $signed(bus.out_imag), k, ev, -ev);
        end
      end else if (bus.do_en !== 1'b0) begin
        n_fail++; $display("FAIL key_change_idle c=%0d: en=%b, expected 0", c, bus.do_en);
      end
      if (c < 10)       drive(1'b1, 24'hFFFFFF, 5000 + c);
      else if (c < 128) drive(1'b1, 24'h000000, 5000 + c);
      else              drive(1'b0, 24'h0, 0);
    end
    $display("test_key_change: done");
  endtask

  task automatic test_output_abort();
    do_reset();
    for (int c = 0; c <= 300; c++) begin
      tick();
      if (c == 150) begin
        n_checks++;
        if (bus.do_en !== 1'b1 || bus.do_count !== 7'd21 || bus.out_real !== 16'd6021) begin
          n_fail++;
          $display("FAIL abort_before: en=%b cnt=%0d re=%0d, expected en=1 cnt=21 re=6021",
                   bus.do_en, bus.do_count, bus.out_real);
        end
        reset = 1'b0;
      end else if (c == 151) begin
        n_checks++;
        if (bus.do_en !== 1'b0 || bus.do_count !== 7'd0 ||
            bus.out_real !== 16'd0 || bus.out_imag !== 16'd0) begin
          n_fail++;
          $display("FAIL abort_at_reset: en=%b cnt=%0d re=%0d im=%0d, expected all 0",
                   bus.do_en, bus.do_count, bus.out_real, bus.out_imag);
        end
        reset = 1'b1;
      end else if (c > 151) begin
        n_checks++;
        if (bus.do_en !== 1'b0) begin
          n_fail++; $display("FAIL abort_after c=%0d: en=%b, expected 0", c, bus.do_en);
        end
      end
      if (c < 128) drive(1'b1, 24'h0, 6000 + c); else drive(1'b0, 24'h0, 0);
    end
    $display("test_output_abort: done");
  endtask

  initial begin
    drive(1'b0, 24'h0, 0);
    test_reset();
    test_identity();
    test_permuted();
    test_back_to_back();
    test_gap();
    test_reset_mid_frame();
    test_key_change();
    test_output_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
